// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//
// Purpose
//   Parallel-in, serial-out transmitter for the serial shift-register links.
//   It takes WIDTH-bit words over a valid/ready handshake and shifts each word
//   out one bit per clock on 'so'. Word boundaries are marked with
//   'frame_start' (first bit) and 'last' (final bit). A one-word holding
//   buffer sits in front of the shifter, so a word waiting there is loaded in
//   the same cycle the previous word's final bit goes out. Back-to-back words
//   therefore leave no idle bit between them.
//
// Parameters
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  1: din[WIDTH-1] is sent first, 0: din[0] is sent first
//   IDLE_LEVEL level driven on 'so' while no word is being shifted
//
// Ports
//   clk          in   1      clock, all logic on the rising edge
//   rst          in   1      synchronous, active-high reset
//   din          in   WIDTH  parallel word to transmit
//   din_valid    in   1      din holds a valid word
//   din_ready    out  1      block can accept din this cycle
//   so           out  1      serial data out
//   so_valid     out  1      'so' carries a data bit this cycle
//   frame_start  out  1      'so' carries the first bit of a word
//   last         out  1      'so' carries the final bit of a word
//   busy         out  1      shifting, or holding buffer occupied
// -----------------------------------------------------------------------------
module piso_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             so,
  output logic             so_valid,
  output logic             frame_start,
  output logic             last,
  output logic             busy
);

  // The bit counter has to reach WIDTH-1.
  localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic at_last;
  logic load_now;
  logic accept;

  // at_last is high while the final bit of the current word is on 'so'.
  // A held word may enter the shifter when the shifter is idle, or when the
  // shifter is about to finish. In that second case the handover leaves no gap.
  assign at_last  = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
  assign load_now = hold_full_q && ((state_q == ST_IDLE) || at_last);

  // The buffer can take a new word when it is empty, or when it is being
  // emptied into the shifter on this same edge. Reset masks ready, so a word
  // offered during reset is never accepted.
  assign din_ready = ~rst & (~hold_full_q | load_now);
  assign accept    = din_valid & din_ready;

  // Holding buffer: a load empties it. A simultaneous accept refills it with
  // the new word, while the shifter takes the old contents.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (load_now) begin
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_d      = din;
      hold_full_d = 1'b1;
    end
  end

  // Shifter FSM. While a word is in flight, the shifter moves its data toward
  // the output end and fills with zeros. On the final bit it either reloads
  // from the buffer or falls back to idle.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (load_now) begin
          sreg_d  = hold_q;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!at_last) begin
          cnt_d  = cnt_q + CNT_W'(1);
          sreg_d = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                             : {1'b0, sreg_q[WIDTH-1:1]};
        end else if (load_now) begin
          sreg_d  = hold_q;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          sreg_d  = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers. Reset aborts any word in flight and discards the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sreg_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
    end
  end

  // Every serial output comes straight from registers. There is no
  // combinational path from din to so.
  assign so_valid    = (state_q == ST_SHIFT);
  assign so          = so_valid ? (MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0])
                                : IDLE_LEVEL;
  assign frame_start = so_valid && (cnt_q == '0);
  assign last        = at_last;
  assign busy        = so_valid | hold_full_q;

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//
// Purpose
//   Self-checking bench for piso_serializer. dut_a uses MSB_FIRST=1 and
//   IDLE_LEVEL=0. dut_b uses MSB_FIRST=0 and IDLE_LEVEL=1. Both share the
//   clock and reset.
//   The outputs of each DUT are packed into one observation vector:
//   {so, so_valid, frame_start, last, busy, din_ready}.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din_a, din_b;
  logic         din_valid_a, din_valid_b;
  logic         din_ready_a, so_a, so_valid_a, frame_start_a, last_a, busy_a;
  logic         din_ready_b, so_b, so_valid_b, frame_start_b, last_b, busy_b;
  logic [5:0]   obs_a, obs_b;

  int n_cmp = 0;
  int n_bad = 0;

  // Schedule-level reference model. For each accepted word it records:
  //   a - the edge index at which the word was accepted
  //   s - the edge index at which the word's first bit appears
  // Word k occupies 'so' after edges s .. s+W-1. It sits in the holding
  // buffer after edges a .. s-1.
  typedef struct {
    logic [W-1:0] w;
    int           a;
    int           s;
  } word_t;

  word_t sched[$];

  assign obs_a = {so_a, so_valid_a, frame_start_a, last_a, busy_a, din_ready_a};
  assign obs_b = {so_b, so_valid_b, frame_start_b, last_b, busy_b, din_ready_b};

  // Free-running clock.
  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_a (
    .clk(clk), .rst(rst), .din(din_a), .din_valid(din_valid_a),
    .din_ready(din_ready_a), .so(so_a), .so_valid(so_valid_a),
    .frame_start(frame_start_a), .last(last_a), .busy(busy_a)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_b (
    .clk(clk), .rst(rst), .din(din_b), .din_valid(din_valid_b),
    .din_ready(din_ready_b), .so(so_b), .so_valid(so_valid_b),
    .frame_start(frame_start_b), .last(last_b), .busy(busy_b)
  );

  // Expected dut_a observation after edge e. The expected din_ready refers to
  // whether the upcoming edge e+1 can accept a word.
  function automatic logic [5:0] model_obs(int e);
    logic so_e = 1'b0;
    logic sv   = 1'b0;
    logic fs   = 1'b0;
    logic ls   = 1'b0;
    logic hf   = 1'b0;
    logic rdy  = 1'b1;
    int   i;
    foreach (sched[k]) begin
      if (sched[k].s <= e && e <= sched[k].s + W - 1) begin
        i    = e - sched[k].s;
        so_e = sched[k].w[W-1-i];
        sv   = 1'b1;
        fs   = (i == 0);
        ls   = (i == W - 1);
      end
      if (sched[k].a <= e && e < sched[k].s) hf = 1'b1;
      if (sched[k].a <= e && e + 1 < sched[k].s) rdy = 1'b0;
    end
    return {so_e, sv, fs, ls, sv | hf, rdy};
  endfunction

  // Reset values while reset is held, then ready on the first free cycle.
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs_a !== 6'b000000) begin
      n_bad++;
      $display("[TB] FAIL reset_a: got %b want %b", obs_a, 6'b000000);
    end
    n_cmp++;
    if (obs_b !== 6'b100000) begin
      n_bad++;
      $display("[TB] FAIL reset_b: got %b want %b", obs_b, 6'b100000);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (obs_a !== 6'b000001) begin
      n_bad++;
      $display("[TB] FAIL reset_release: got %b want %b", obs_a, 6'b000001);
    end
    @(negedge clk);
  endtask

  // One 8'h0F word, MSB first: 0,0,0,0,1,1,1,1.
  task automatic test_single_msb();
    logic [7:0] seq = 8'b00001111;
    logic [5:0] exp;
    din_a = 8'h0F;
    din_valid_a = 1'b1;
    @(negedge clk);
    din_valid_a = 1'b0;
    n_cmp++;
    if (obs_a !== 6'b000011) begin
      n_bad++;
      $display("[TB] FAIL single_msb_pre: got %b want %b", obs_a, 6'b000011);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp = {seq[7-i], 1'b1, (i == 0), (i == 7), 1'b1, 1'b1};
      n_cmp++;
      if (obs_a !== exp) begin
        n_bad++;
        $display("[TB] FAIL single_msb bit %0d: got %b want %b", i, obs_a, exp);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (obs_a !== 6'b000001) begin
      n_bad++;
      $display("[TB] FAIL single_msb_post: got %b want %b", obs_a, 6'b000001);
    end
  endtask

  // One 8'h0F word, LSB first, idle level 1: 1,1,1,1,0,0,0,0.
  task automatic test_single_lsb();
    logic [7:0] seq = 8'b11110000;
    logic [5:0] exp;
    din_b = 8'h0F;
    din_valid_b = 1'b1;
    @(negedge clk);
    din_valid_b = 1'b0;
    n_cmp++;
    if (obs_b !== 6'b100011) begin
      n_bad++;
      $display("[TB] FAIL single_lsb_pre: got %b want %b", obs_b, 6'b100011);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp = {seq[7-i], 1'b1, (i == 0), (i == 7), 1'b1, 1'b1};
      n_cmp++;
      if (obs_b !== exp) begin
        n_bad++;
        $display("[TB] FAIL single_lsb bit %0d: got %b want %b", i, obs_b, exp);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (obs_b !== 6'b100001) begin
      n_bad++;
      $display("[TB] FAIL single_lsb_post: got %b want %b", obs_b, 6'b100001);
    end
  endtask

  // Words A5 and 3C go out back to back. FF is offered while A5 shifts and 3C
  // is held. FF must wait for A5's last bit and then follow 3C with no gap.
  task automatic test_back_to_back();
    logic [23:0] stream = 24'hA53CFF;
    logic [5:0]  exp;
    logic        sv;
    din_a = 8'hA5;
    din_valid_a = 1'b1;
    @(negedge clk);
    din_a = 8'h3C;
    @(negedge clk);
    din_a = 8'hFF;
    for (int k = 0; k < 26; k++) begin
      sv  = (k < 24);
      exp = {sv ? stream[23-k] : 1'b0, sv, sv && (k % 8 == 0),
             sv && (k % 8 == 7), sv, (k == 7) || (k >= 15)};
      n_cmp++;
      if (obs_a !== exp) begin
        n_bad++;
        $display("[TB] FAIL back_to_back cyc %0d: got %b want %b", k, obs_a, exp);
      end
      if (k == 8) din_valid_a = 1'b0;
      @(negedge clk);
    end
  endtask

  // Reset arrives while bit 4 of A5 is on 'so' and 3C is held. A word offered
  // in the reset cycle must be ignored, and nothing may come out afterwards.
  task automatic test_reset_mid_word();
    din_a = 8'hA5;
    din_valid_a = 1'b1;
    @(negedge clk);
    din_a = 8'h3C;
    @(negedge clk);
    din_valid_a = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs_a !== 6'b010010) begin
      n_bad++;
      $display("[TB] FAIL mid_word_bit4: got %b want %b", obs_a, 6'b010010);
    end
    rst = 1'b1;
    din_a = 8'hFF;
    din_valid_a = 1'b1;
    #1;
    n_cmp++;
    if (obs_b !== 6'b100000) begin
      n_bad++;
      $display("[TB] FAIL rst_masks_ready: got %b want %b", obs_b, 6'b100000);
    end
    @(negedge clk);
    n_cmp++;
    if (obs_a !== 6'b000000) begin
      n_bad++;
      $display("[TB] FAIL mid_word_reset: got %b want %b", obs_a, 6'b000000);
    end
    rst = 1'b0;
    din_valid_a = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_a !== 6'b000001) begin
        n_bad++;
        $display("[TB] FAIL mid_word_residue cyc %0d: got %b want %b", i, obs_a, 6'b000001);
      end
    end
  endtask

  // With no traffic and IDLE_LEVEL=1, 'so' stays at 1 and the block stays ready.
  task automatic test_idle_level();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_b !== 6'b100001) begin
        n_bad++;
        $display("[TB] FAIL idle_level cyc %0d: got %b want %b", i, obs_b, 6'b100001);
      end
    end
  endtask

  // Random traffic on dut_a is checked against the schedule model. In the
  // first half, valid is high about 3/4 of the time; in the second half,
  // about 1/4. At the end the bench stops offering words and lets the DUT drain.
  task automatic test_random();
    int         e      = 0;
    int         last_s = -100;
    int         s;
    logic [5:0] exp;
    sched.delete();
    for (int c = 0; c < 620; c++) begin
      exp = model_obs(e);
      n_cmp++;
      if (obs_a !== exp) begin
        n_bad++;
        $display("[TB] FAIL random cyc %0d: got %b want %b", c, obs_a, exp);
      end
      if (c < 300)      din_valid_a = ($urandom_range(0, 3) != 0);
      else if (c < 600) din_valid_a = ($urandom_range(0, 3) == 0);
      else              din_valid_a = 1'b0;
      din_a = W'($urandom);
      if (din_valid_a && exp[0]) begin
        s = (e + 2 > last_s + W) ? e + 2 : last_s + W;
        sched.push_back('{din_a, e + 1, s});
        last_s = s;
      end
      @(negedge clk);
      e++;
    end
  endtask

  // Stops a hung run with a failure line.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Runs each scenario in sequence, then prints the summary line.
  initial begin
    rst         = 1'b1;
    din_a       = '0;
    din_b       = '0;
    din_valid_a = 1'b0;
    din_valid_b = 1'b0;
    test_reset();
    test_single_msb();
    test_single_lsb();
    test_back_to_back();
    test_reset_mid_word();
    test_idle_level();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
